ssaw_mix: RTL and testbench



---
 rtl/ssaw_mix_if.sv | 33 +++
 rtl/ssaw_mix.sv | 149 ++++++++++++++
 tb/tb_ssaw_mix.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/ssaw_mix_if.sv
`timescale 1ns/1ps
// ssaw_mix_if
// Groups the signals between the supersaw voice, the seven-tap mixer and the
// VCA/DAC path.
//   ss1..ss7     : 8-bit unsigned oscillator taps (voice -> mixer)
//   gain         : 7-bit output gain, multiplier (gain+1)/128 (voice -> mixer)
//   signal_out   : 8-bit mixed sample, held between updates (mixer -> DAC)
//   sample_valid : one-cycle pulse when signal_out updates (mixer -> DAC)
//   overrun      : sticky flag, strobe seen while busy (mixer -> DAC)
// master = voice / test driver side, slave = mixer side.
interface ssaw_mix_if;
    logic [7:0] ss1;
    logic [7:0] ss2;
    logic [7:0] ss3;
    logic [7:0] ss4;
    logic [7:0] ss5;
    logic [7:0] ss6;
    logic [7:0] ss7;
    logic [6:0] gain;
    logic [7:0] signal_out;
    logic       sample_valid;
    logic       overrun;

    modport master (
        output ss1, ss2, ss3, ss4, ss5, ss6, ss7, gain,
        input  signal_out, sample_valid, overrun
    );

    modport slave (
        input  ss1, ss2, ss3, ss4, ss5, ss6, ss7, gain,
        output signal_out, sample_valid, overrun
    );
endinterface

// File: rtl/ssaw_mix.sv
`timescale 1ns/1ps
// ssaw_mix
// Seven-tap supersaw mixer. Once per SAMPLE_DIV clocks all seven taps are
// captured together, summed serially (one tap per clock), normalised to 8 bits
// with a x147/1024 (~1/7) scale and saturation, then multiplied by
// (gain+1)/128 and presented with a one-cycle sample_valid pulse.
//
// Ports:
//   clk : system clock
//   rst : asynchronous active-high reset
//   bus : ssaw_mix_if.slave (taps and gain in; signal_out, sample_valid,
//         overrun out)
// Parameter:
//   SAMPLE_DIV : clocks per output sample (10..65535)
// Optional feature macro:
//   SSAW_MIX_DITHER_EN : adds a 16-bit LFSR whose low 3 bits are added to the
//                        accumulated sum before scaling.
module ssaw_mix #(
    parameter int unsigned SAMPLE_DIV = 1042
) (
    input  logic       clk,
    input  logic       rst,
    ssaw_mix_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC   = 2'd1,
        SCALE = 2'd2,
        OUT   = 2'd3
    } state_t;

    state_t      state_reg;
    logic [15:0] div_reg;
    logic [10:0] acc_reg;
    logic [2:0]  idx_reg;
    logic [7:0]  norm_reg;
    logic [7:0]  signal_out_reg;
    logic        sample_valid_reg;
    logic        overrun_reg;
    logic [7:0]  snap_reg [7];

    logic [7:0]  tap [7];
    logic        strobe;
    logic [11:0] scale_in;
    logic [8:0]  scaled;
    logic [7:0]  norm_next;
    logic [7:0]  gain_p1;
    logic [7:0]  out_next;

    assign tap[0] = bus.ss1;
    assign tap[1] = bus.ss2;
    assign tap[2] = bus.ss3;
    assign tap[3] = bus.ss4;
    assign tap[4] = bus.ss5;
    assign tap[5] = bus.ss6;
    assign tap[6] = bus.ss7;

    assign strobe = (div_reg == 16'(SAMPLE_DIV - 1));

`ifdef SSAW_MIX_DITHER_EN
    // Fibonacci LFSR, taps 16,15,13,4; steps once per sample strobe so the
    // dither value is constant for the whole sample in flight.
    logic [15:0] lfsr_reg;
    logic        lfsr_fb;

    assign lfsr_fb = lfsr_reg[15] ^ lfsr_reg[14] ^ lfsr_reg[12] ^ lfsr_reg[3];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_reg <= 16'hACE1;
        end else if (strobe) begin
            lfsr_reg <= {lfsr_reg[14:0], lfsr_fb};
        end
    end

    assign scale_in = {1'b0, acc_reg} + {9'b0, lfsr_reg[2:0]};
`else
    assign scale_in = {1'b0, acc_reg};
`endif

    // (scale_in * 147) >> 10 fits in 9 bits; bit 8 set means the result
    // exceeds 255 and must saturate.
    assign scaled    = 9'(({7'b0, scale_in} * 19'd147) >> 10);
    assign norm_next = scaled[8] ? 8'hFF : scaled[7:0];

    // (gain+1) ranges 1..128, so norm * (gain+1) >> 7 never exceeds norm.
    assign gain_p1  = {1'b0, bus.gain} + 8'd1;
    assign out_next = 8'(({7'b0, norm_reg} * {7'b0, gain_p1}) >> 7);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg        <= IDLE;
            div_reg          <= 16'd0;
            acc_reg          <= 11'd0;
            idx_reg          <= 3'd0;
            norm_reg         <= 8'd0;
            signal_out_reg   <= 8'd0;
            sample_valid_reg <= 1'b0;
            overrun_reg      <= 1'b0;
            for (int i = 0; i < 7; i++) begin
                snap_reg[i] <= 8'd0;
            end
        end else begin
            div_reg          <= strobe ? 16'd0 : div_reg + 16'd1;
            sample_valid_reg <= 1'b0;

            // A strobe landing mid-computation is dropped but remembered.
            if (strobe && state_reg != IDLE) begin
                overrun_reg <= 1'b1;
            end

            case (state_reg)
                IDLE: begin
                    if (strobe) begin
                        for (int i = 0; i < 7; i++) begin
                            snap_reg[i] <= tap[i];
                        end
                        acc_reg   <= 11'd0;
                        idx_reg   <= 3'd0;
                        state_reg <= ACC;
                    end
                end
                ACC: begin
                    acc_reg <= acc_reg + {3'b0, snap_reg[idx_reg]};
                    idx_reg <= idx_reg + 3'd1;
                    if (idx_reg == 3'd6) begin
                        state_reg <= SCALE;
                    end
                end
                SCALE: begin
                    norm_reg  <= norm_next;
                    state_reg <= OUT;
                end
                OUT: begin
                    signal_out_reg   <= out_next;
                    sample_valid_reg <= 1'b1;
                    state_reg        <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.signal_out   = signal_out_reg;
    assign bus.sample_valid = sample_valid_reg;
    assign bus.overrun      = overrun_reg;

endmodule

// File: tb/tb_ssaw_mix.sv
`timescale 1ns/1ps
// tb_ssaw_mix
// Self-checking bench for ssaw_mix at SAMPLE_DIV=16. A reference model counts
// edges since reset release, sums the taps at each strobe edge, and at the
// ninth edge after it pushes the expected sample (value and edge number) into
// a scoreboard queue. A separate monitor pops and compares on every
// sample_valid pulse. Directed checks cover the documented corner cases; a
// randomized run covers 100 samples.
module tb_ssaw_mix;
    localparam int DIV = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    ssaw_mix_if bus();

    ssaw_mix #(.SAMPLE_DIV(DIV)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int val;
        int edge_no;
    } exp_t;

    exp_t sb[$];
    int   edge_cnt;
    int   cap_sum;
    int   cap_edge;
    bit   cap_pending;
    int   total = 0;
    int   bad = 0;
    int   pulse_cnt = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    task automatic set_taps(input int v);
        bus.ss1 = 8'(v);
        bus.ss2 = 8'(v);
        bus.ss3 = 8'(v);
        bus.ss4 = 8'(v);
        bus.ss5 = 8'(v);
        bus.ss6 = 8'(v);
        bus.ss7 = 8'(v);
    endtask

    function automatic int tap_sum();
        return int'(bus.ss1) + int'(bus.ss2) + int'(bus.ss3) + int'(bus.ss4)
             + int'(bus.ss5) + int'(bus.ss6) + int'(bus.ss7);
    endfunction

    // Mixer transfer function: divide-by-~7, clip to 255, apply (g+1)/128.
    function automatic int ref_out(input int sum, input int g);
        int n;
        n = (sum * 147) / 1024;
        if (n > 255) n = 255;
        return (n * (g + 1)) / 128;
    endfunction

    // Reference model: sample captured at each multiple of DIV edges,
    // result due 9 edges later using the gain present at that edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            edge_cnt    <= 0;
            cap_pending <= 1'b0;
            sb.delete();
        end else begin
            if (cap_pending && (edge_cnt + 1 == cap_edge + 9)) begin
                sb.push_back(exp_t'{ref_out(cap_sum, int'(bus.gain)), edge_cnt + 1});
                cap_pending <= 1'b0;
            end
            if ((edge_cnt + 1) % DIV == 0) begin
                cap_sum     <= tap_sum();
                cap_edge    <= edge_cnt + 1;
                cap_pending <= 1'b1;
            end
            edge_cnt <= edge_cnt + 1;
        end
    end

    // Monitor: compares every sample_valid pulse against the scoreboard.
    initial begin
        bit   prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.sample_valid) begin
                pulse_cnt++;
                check("valid_width", int'(prev), 0);
                check("overrun_clear", int'(bus.overrun), 0);
                check("pulse_expected", int'(sb.size()), 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("sample_value", int'(bus.signal_out), e.val);
                    check("sample_edge", edge_cnt, e.edge_no);
                end
            end
            prev = bus.sample_valid;
        end
    end

    // Advance to the negedge following edge n (bounded).
    task automatic wait_edge(input int n);
        int guard;
        guard = 0;
        while (edge_cnt < n && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        if (edge_cnt != n) check("wait_edge", edge_cnt, n);
    endtask

    initial begin
        int p0;
        set_taps(0);
        bus.gain = 7'd127;
        repeat (3) @(negedge clk);
        check("rst_signal_out", int'(bus.signal_out), 0);
        check("rst_sample_valid", int'(bus.sample_valid), 0);
        check("rst_overrun", int'(bus.overrun), 0);

        rst = 1'b0;
        set_taps(100);
        wait_edge(24);
        check("pre_first_valid", int'(bus.sample_valid), 0);
        wait_edge(25);
        check("first_valid_edge25", int'(bus.sample_valid), 1);
        check("all100_g127", int'(bus.signal_out), 100);

        set_taps(255);
        wait_edge(41);
        check("all255_saturate", int'(bus.signal_out), 255);

        set_taps(100);
        bus.gain = 7'd63;
        wait_edge(57);
        check("all100_g63", int'(bus.signal_out), 50);

        set_taps(0);
        bus.gain = 7'd127;
        wait_edge(73);
        check("all0", int'(bus.signal_out), 0);

        // ss1 changes just after the strobe at edge 80.
        wait_edge(80);
        bus.ss1 = 8'd255;
        wait_edge(89);
        check("late_change_current", int'(bus.signal_out), 0);
        wait_edge(105);
        check("late_change_next", int'(bus.signal_out), 36);

        // Reset during ACC of the sample captured at edge 112.
        set_taps(200);
        wait_edge(115);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_signal_out", int'(bus.signal_out), 0);
        check("midrst_valid", int'(bus.sample_valid), 0);
        @(negedge clk);
        rst = 1'b0;
        wait_edge(24);
        check("post_rst_hold", int'(bus.signal_out), 0);
        wait_edge(25);
        check("post_rst_valid_edge", int'(bus.sample_valid), 1);
        check("post_rst_value", int'(bus.signal_out), 200);

        // 100 randomized samples: strobes at 32..1616, results at 41..1625.
        p0 = pulse_cnt;
        for (int c = 0; c < 1605; c++) begin
            @(negedge clk);
            bus.ss1  = 8'($urandom);
            bus.ss2  = 8'($urandom);
            bus.ss3  = 8'($urandom);
            bus.ss4  = 8'($urandom);
            bus.ss5  = 8'($urandom);
            bus.ss6  = 8'($urandom);
            bus.ss7  = 8'($urandom);
            bus.gain = 7'($urandom);
        end
        check("random_pulse_count", pulse_cnt - p0, 100);
        check("final_overrun", int'(bus.overrun), 0);
        check("scoreboard_drained", int'(sb.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
